sw_alloc_5p: RTL and testbench

- Packet-level switch allocator for one 5-port mesh router (4x4 mesh).
- Takes per-input one-hot route requests from the route-compute stage and grants each output port to one input at a time.
- A grant holds from header flit to tail flit (wormhole lock). Arbitration is round-robin per output.
- Drives the crossbar select lines, the per-input buffer pop strobes and the per-output valid.

---
 rtl/sw_alloc_5p_pkg.sv | 58 +++++
 rtl/sw_alloc_5p_arb.sv | 102 ++++++++++
 rtl/sw_alloc_5p.sv | 61 ++++++
 tb/tb_sw_alloc_5p.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_alloc_5p_pkg.sv
// Shared router definitions for the 5-port switch allocator: port indices,
// route-compute codes, flit types, arbiter state and the round-robin pick helper.
package sw_alloc_5p_pkg;

  localparam int NUM_PORTS = 5;
  localparam int SEL_W     = 3;
  localparam int WD_CYCLES = 64;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_W = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_N = 3'd4;

  // Route-compute output codes, kept for the neighbouring stage.
  localparam logic [2:0] RC_LO = 3'd1;
  localparam logic [2:0] RC_EO = 3'd2;
  localparam logic [2:0] RC_NO = 3'd3;
  localparam logic [2:0] RC_WO = 3'd4;
  localparam logic [2:0] RC_SO = 3'd5;

  localparam logic [2:0] NO_OWNER = 3'd7;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HDR    = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e state;
    logic [2:0] rr_ptr;
  } arb_dbg_t;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Returns {hit, index} of the first set request at or after ptr, modulo 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] pick;
    logic [2:0] idx;
    pick = {1'b0, NO_OWNER};
    idx  = ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick[3] && req[idx]) pick = {1'b1, idx};
      idx = next_port(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/sw_alloc_5p_arb.sv
// sa_out_arbiter: one output port's round-robin arbiter with wormhole lock.
// SA_WATCHDOG_EN adds a stall watchdog that force-releases a stuck lock.
module sa_out_arbiter
  import sw_alloc_5p_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [2*NUM_PORTS-1:0] in_type,
  input  logic                   out_ready,
`ifdef SA_WATCHDOG_EN
  output logic                   wd_err,
`endif
  output logic                   out_valid,
  output logic [NUM_PORTS-1:0]   pop,
  output logic [SEL_W-1:0]       sel,
  output arb_dbg_t               dbg
);

  arb_state_e state, state_n;
  logic [2:0] owner, owner_n, rr_ptr, rr_n;
  logic [3:0] pick;
  logic       owner_valid, owner_last, xfer, release_now, wd_fire;

  // TAIL and SINGLE both carry type bit 0, which marks the packet's last flit.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == 3'(i)) begin
        owner_valid = in_valid[i];
        owner_last  = in_type[2*i];
      end
    end
  end

  assign xfer = (state == ARB_LOCKED) && owner_valid && out_ready;

`ifdef SA_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == ARB_LOCKED) && !xfer && (wd_cnt == WD_W'(WD_CYCLES - 1));
  assign wd_err  = wd_fire;

  always_ff @(posedge clk) begin
    if (rst || state != ARB_LOCKED || xfer || wd_fire) wd_cnt <= '0;
    else                                              wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign release_now = (xfer && owner_last) || wd_fire;

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    pick    = rr_pick(req, rr_ptr);
    case (state)
      ARB_IDLE: begin
        if (pick[3]) begin
          state_n = ARB_LOCKED;
          owner_n = pick[2:0];
        end
      end
      ARB_LOCKED: begin
        if (release_now) begin
          state_n = ARB_IDLE;
          owner_n = NO_OWNER;
          rr_n    = next_port(owner);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= NO_OWNER;
      rr_ptr <= 3'd0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
    end
  end

  assign out_valid = (state == ARB_LOCKED) && owner_valid;
  assign sel       = owner;
  assign dbg       = {state, rr_ptr};

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (xfer && owner == 3'(i)) pop[i] = 1'b1;
    end
  end

endmodule

// File: rtl/sw_alloc_5p.sv
// sw_alloc_5p: 5-port packet switch allocator, one locking arbiter per output.
// Handshake: a flit moves on output j when out_valid[j] & out_ready[j]; in_pop marks it at the source. Optional: SA_WATCHDOG_EN.
module sw_alloc_5p
  import sw_alloc_5p_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       in_valid,
  input  logic [2*NUM_PORTS-1:0]     in_type,
  input  logic [NUM_PORTS*5-1:0]     in_req,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [NUM_PORTS-1:0]       in_pop,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [NUM_PORTS*SEL_W-1:0] out_sel,
`ifdef SA_WATCHDOG_EN
  output logic [NUM_PORTS-1:0]       wd_err,
`endif
  output arb_dbg_t [NUM_PORTS-1:0]   arb_dbg
);

  logic [NUM_PORTS-1:0] req_lo [NUM_PORTS];
  logic [NUM_PORTS-1:0] req_t  [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop_m  [NUM_PORTS];

  // Only headers (type bit 1 set) request; a multi-hot route keeps its lowest bit.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    logic [4:0] r;
    assign r         = in_req[5*i +: 5];
    assign req_lo[i] = (in_valid[i] && in_type[2*i+1]) ? (r & (~r + 5'd1)) : '0;
  end

  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) req_t[j][i] = req_lo[i][j];
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    sa_out_arbiter u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_t[j]),
      .in_valid  (in_valid),
      .in_type   (in_type),
      .out_ready (out_ready[j]),
`ifdef SA_WATCHDOG_EN
      .wd_err    (wd_err[j]),
`endif
      .out_valid (out_valid[j]),
      .pop       (pop_m[j]),
      .sel       (out_sel[SEL_W*j +: SEL_W]),
      .dbg       (arb_dbg[j])
    );
  end

  always_comb begin
    in_pop = '0;
    for (int j = 0; j < NUM_PORTS; j++) in_pop = in_pop | pop_m[j];
  end

endmodule

// File: tb/tb_sw_alloc_5p.sv
// Bench for sw_alloc_5p: upstream buffer queues, random/directed packets,
// a rule-level allocation model and a per-input expected-flit scoreboard.
`timescale 1ns/1ps
module tb_sw_alloc_5p;
  import sw_alloc_5p_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  in_valid, out_ready, in_pop, out_valid;
  logic [9:0]  in_type;
  logic [24:0] in_req;
  logic [14:0] out_sel;
  arb_dbg_t [4:0] arb_dbg;
`ifdef SA_WATCHDOG_EN
  logic [4:0]  wd_err;
`endif

  sw_alloc_5p dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type), .in_req(in_req),
    .out_ready(out_ready), .in_pop(in_pop), .out_valid(out_valid), .out_sel(out_sel),
`ifdef SA_WATCHDOG_EN
    .wd_err(wd_err),
`endif
    .arb_dbg(arb_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ftype;
    logic [2:0] dest;
    logic [4:0] req;
    logic [7:0] pid;
  } flit_t;

  flit_t       in_q  [5][$];
  logic [17:0] exp_q [5][$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  hold_mask  = '0;
  logic [4:0]  stall_mask = '0;
  bit          rand_mode  = 1'b0;
  logic [4:0]  pop_s      = '0;
  logic [2:0]  m_owner [5];
  logic [2:0]  m_rr    [5];
  int          m_wd    [5];
  logic [7:0]  pid_ctr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [4:0] r);
    for (int b = 0; b < 5; b++) if (r[b]) return 3'(b);
    return NO_OWNER;
  endfunction

  task automatic push_flit(input int i, input logic [1:0] ft, input logic [2:0] dest, input logic [4:0] req);
    flit_t f;
    f.ftype = ft; f.dest = dest; f.req = req; f.pid = pid_ctr;
    in_q[i].push_back(f);
    exp_q[i].push_back(f);
  endtask

  // Header route is one-hot on dest plus random junk above it (lowest bit wins).
  task automatic push_pkt(input int i, input logic [2:0] dest, input int len);
    logic [4:0] one, above, hreq;
    pid_ctr++;
    one   = 5'd1 << dest;
    above = ~((one << 1) - 5'd1);
    hreq  = one | (5'($urandom) & above);
    if (len == 1) push_flit(i, SINGLE, dest, hreq);
    else begin
      push_flit(i, HDR, dest, hreq);
      for (int b = 0; b < len - 2; b++) push_flit(i, BODY, dest, 5'($urandom));
      push_flit(i, TAIL, dest, 5'($urandom));
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 5; i++) if (in_q[i].size() != 0 || m_owner[i] != NO_OWNER) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #2;
      if (all_idle()) return;
    end
    n_checks++; n_fail++;
    $display("FAIL drain_timeout: actual busy required idle within %0d cycles", budget);
  endtask

  // Upstream buffers: apply the pops seen last cycle, present new heads.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 5; i++) if (pop_s[i] && in_q[i].size() > 0) in_q[i].delete(0);
    hold_mask = rand_mode ? (5'($urandom) & 5'($urandom)) : 5'd0;
    for (int i = 0; i < 5; i++) begin
      if (in_q[i].size() > 0 && !hold_mask[i]) begin
        in_valid[i]       = 1'b1;
        in_type[2*i +: 2] = in_q[i][0].ftype;
        in_req[5*i +: 5]  = in_q[i][0].req;
      end else begin
        in_valid[i]       = 1'b0;
        in_type[2*i +: 2] = 2'($urandom);
        in_req[5*i +: 5]  = 5'($urandom);
      end
    end
    for (int j = 0; j < 5; j++)
      out_ready[j] = !stall_mask[j] && (!rand_mode || $urandom_range(0, 3) != 0);
  end

  // Monitor: compare outputs against the allocation model, then advance it.
  always @(negedge clk) begin
    logic [4:0]  e_valid, e_pop, e_wd;
    logic [14:0] e_sel;
    logic [2:0]  o;
    logic [2:0]  lo [5];
    flit_t       fr;
    int          c;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        in_q[i].delete(); exp_q[i].delete();
        m_owner[i] = NO_OWNER; m_rr[i] = 3'd0; m_wd[i] = 0;
      end
      pop_s = '0;
    end else begin
      for (int i = 0; i < 5; i++) lo[i] = lowest(in_req[5*i +: 5]);
      e_valid = '0; e_pop = '0; e_sel = '0; e_wd = '0;
      for (int j = 0; j < 5; j++) begin
        o = m_owner[j];
        e_sel[3*j +: 3] = o;
        if (o != NO_OWNER) begin
          e_valid[j] = in_valid[o];
          if (in_valid[o] && out_ready[j]) e_pop[o] = 1'b1;
`ifdef SA_WATCHDOG_EN
          else if (m_wd[j] == WD_CYCLES - 1) e_wd[j] = 1'b1;
`endif
        end
      end
      check("out_sel", 32'(out_sel), 32'(e_sel));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("in_pop", 32'(in_pop), 32'(e_pop));
`ifdef SA_WATCHDOG_EN
      check("wd_err", 32'(wd_err), 32'(e_wd));
`endif
      for (int j = 0; j < 5; j++) begin
        check($sformatf("locked_%0d", j), 32'(arb_dbg[j].state), 32'(m_owner[j] != NO_OWNER));
        check($sformatf("rr_ptr_%0d", j), 32'(arb_dbg[j].rr_ptr), 32'(m_rr[j]));
      end
      for (int j = 0; j < 5; j++) begin
        o = m_owner[j];
        if (o != NO_OWNER) begin
          if (in_valid[o] && out_ready[j]) begin
            m_wd[j] = 0;
            if (exp_q[o].size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL sb_underflow: actual transfer from input %0d required none", o);
            end else begin
              fr = exp_q[o].pop_front();
              check("sb_dest", 32'(fr.dest), 32'(j));
              if (fr.ftype == TAIL || fr.ftype == SINGLE) begin
                m_owner[j] = NO_OWNER;
                m_rr[j]    = 3'((int'(o) + 1) % 5);
              end
            end
          end else if (e_wd[j]) begin
            m_wd[j] = 0; m_owner[j] = NO_OWNER; m_rr[j] = 3'((int'(o) + 1) % 5);
          end else m_wd[j]++;
        end else begin
          for (int k = 0; k < 5; k++) begin
            c = (int'(m_rr[j]) + k) % 5;
            if (m_owner[j] == NO_OWNER && in_valid[c] && in_type[2*c+1] && lo[c] == 3'(j))
              m_owner[j] = 3'(c);
          end
        end
      end
      pop_s = in_pop;
    end
  end

  initial begin
    in_valid = '0; in_type = '0; in_req = '0; out_ready = '1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_sel", 32'(out_sel), 32'h7fff);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pop", 32'(in_pop), 32'h0);

    // Single packet E -> N: one arbitration cycle, then three transfers.
    @(posedge clk); #2;
    push_pkt(1, P_N, 3);
    repeat (2) @(negedge clk);
    check("sp_arb_cycle_valid", 32'(out_valid[4]), 32'h0);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      check("sp_sel", 32'(out_sel[14:12]), 32'h1);
      check("sp_pop", 32'(in_pop), 32'h2);
    end
    @(negedge clk);
    check("sp_sel_release", 32'(out_sel[14:12]), 32'h7);
    wait_drain(50);

    // Contention L, W, S -> E.
    push_pkt(0, P_E, 1); push_pkt(2, P_E, 1); push_pkt(3, P_E, 1);
    wait_drain(100);
    check("cont_rr_ptr", 32'(arb_dbg[1].rr_ptr), 32'h4);

    // Backpressure on N mid-packet.
    push_pkt(1, P_N, 6);
    repeat (3) @(posedge clk);
    #2 stall_mask = 5'b10000;
    repeat (3) @(negedge clk);
    check("bp_pop", 32'(in_pop[1]), 32'h0);
    check("bp_sel", 32'(out_sel[14:12]), 32'h1);
    repeat (3) @(posedge clk);
    #2 stall_mask = 5'b00000;
    wait_drain(100);

    // Parallel L -> N and N -> S.
    push_pkt(0, P_N, 4); push_pkt(4, P_S, 4);
    repeat (3) @(negedge clk);
    check("par_pop", 32'(in_pop), 32'h11);
    wait_drain(100);

    // Random traffic with holds and backpressure.
    rand_mode = 1'b1;
    repeat (400) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 2) == 0) begin
        int i;
        i = $urandom_range(0, 4);
        if (in_q[i].size() < 12) push_pkt(i, 3'($urandom_range(0, 4)), $urandom_range(1, 5));
      end
    end
    wait_drain(4000);
    rand_mode = 1'b0;

`ifdef SA_WATCHDOG_EN
    // Owner stalls after its header; watchdog hands output L to input S.
    pid_ctr++;
    push_flit(2, HDR, P_L, 5'b00001);
    push_pkt(3, P_L, 1);
    wait_drain(WD_CYCLES + 50);
`endif

    // A header with an empty route is never granted.
    @(posedge clk); #2;
    push_flit(2, SINGLE, NO_OWNER, 5'b00000);
    repeat (10) @(negedge clk);
    check("zero_req_valid", 32'(out_valid), 32'h0);

    // Reset while output E is locked mid-packet.
    @(posedge clk); #2;
    push_pkt(0, P_E, 4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_sel", 32'(out_sel[5:3]), 32'h7);
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_rr", 32'(arb_dbg[1].rr_ptr), 32'h0);

    @(posedge clk); #2;
    push_pkt(3, P_W, 2);
    wait_drain(100);
    for (int i = 0; i < 5; i++) check($sformatf("sb_empty_%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
